// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants for the instruction-fetch prefetch front end.
package fetch_prefetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    // Instruction presented to decode when nothing is buffered.
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0000;

    // Fetch PC after reset unless the top is overridden.
    localparam logic [31:0] DEFAULT_INITIAL_PC = 32'h0000_0000;

    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous first-word-fall-through FIFO with synchronous flush and occupancy count.
module fetch_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    input  logic                            pop,
    output logic                            head_valid,
    output logic [WIDTH-1:0]                head_data,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_valid = !empty;
    assign head_data  = mem[rd_ptr[AW-1:0]];
    assign count      = CW'(wr_ptr - rd_ptr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF-stage prefetcher: in-order imem requests, PC-tagged FWFT buffer, redirect flush with stale-response drop.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 4,
    parameter logic [XLEN-1:0] INITIAL_PC      = XLEN'(DEFAULT_INITIAL_PC)
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          imem_req,
    output logic [XLEN-1:0]               imem_addr,
    input  logic                          imem_ready,
    input  logic                          imem_valid,
    input  logic [INSTR_W-1:0]            imem_rdata,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          id_valid,
    input  logic                          id_ready,
    output logic [INSTR_W-1:0]            id_instr,
    output logic [XLEN-1:0]               id_pc,
    output logic [count_width(DEPTH)-1:0] buf_count
);

    localparam int unsigned CNT_W   = count_width(DEPTH);
    localparam int unsigned OUT_W   = count_width(MAX_OUTSTANDING);
    localparam int unsigned SUM_W   = CNT_W + OUT_W + 1;
    localparam int unsigned ENTRY_W = INSTR_W + XLEN;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    fetch_pc_next;
    logic [XLEN-1:0]    resp_pc;
    logic [XLEN-1:0]    resp_pc_next;
    logic [OUT_W-1:0]   inflight;
    logic [OUT_W-1:0]   inflight_next;
    logic [OUT_W-1:0]   drop;
    logic [OUT_W-1:0]   drop_next;
    logic [SUM_W-1:0]   occupancy;
    logic [XLEN-1:0]    redirect_target;
    logic               accept;
    logic               resp_keep;
    logic               pop;
    logic               fifo_valid;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [1:0]         unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = redirect_pc[1:0];

    // Buffer slots already promised: stored words plus live (non-dropped) requests.
    assign occupancy = SUM_W'(buf_count) + SUM_W'(inflight) - SUM_W'(drop);

    assign imem_req  = reset && !redirect
                    && (inflight < OUT_W'(MAX_OUTSTANDING))
                    && (occupancy < SUM_W'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;

    assign resp_keep  = imem_valid && (drop == '0) && !redirect;
    assign fifo_wdata = {imem_rdata, resp_pc};
    assign pop        = fifo_valid && id_ready && !redirect;

    always_comb begin
        fetch_pc_next = fetch_pc;
        resp_pc_next  = resp_pc;
        inflight_next = inflight + OUT_W'(accept) - OUT_W'(imem_valid);
        drop_next     = drop;
        if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc_next = redirect_target;
            resp_pc_next  = redirect_target;
            drop_next     = inflight_next;
        end else begin
            if (accept) begin
                fetch_pc_next = fetch_pc + XLEN'(PC_STEP);
            end
            if (resp_keep) begin
                resp_pc_next = resp_pc + XLEN'(PC_STEP);
            end
            if (imem_valid && (drop != '0)) begin
                drop_next = drop - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= INITIAL_PC;
            resp_pc  <= INITIAL_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;
            resp_pc  <= resp_pc_next;
            inflight <= inflight_next;
            drop     <= drop_next;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (resp_keep),
        .push_data  (fifo_wdata),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_data  (fifo_head),
        .count      (buf_count)
    );

    assign id_valid = fifo_valid;
    assign id_instr = fifo_valid ? fifo_head[ENTRY_W-1:XLEN] : BUBBLE_INSTR;
    assign id_pc    = fifo_valid ? fifo_head[XLEN-1:0] : '0;

    a_resp_without_request : assert property (@(posedge clock) disable iff (!reset)
        !(imem_valid && (inflight == '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: pipelined memory model plus expected-output scoreboard.
module tb_fetch_prefetch_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 4;
    localparam logic [31:0] INIT_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [2:0]  buf_count;

    fetch_prefetch_unit #(
        .XLEN            (XLEN),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .INITIAL_PC      (INIT_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .buf_count   (buf_count)
    );

    always #5 clock = ~clock;

    mreq_t       mq[$];
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          pops = 0;
    int          first_valid = -1;
    int          max_infl = 0;
    bit          mem_rand = 0;
    bit          mem_block = 0;
    bit          idr_rand = 0;
    bit          idr = 1;
    bit          redir_on_resp = 0;
    logic [31:0] exp_fetch = INIT_PC;
    logic [31:0] auto_pc = 32'h0000_0203;
    logic        s_id_valid;
    logic [31:0] s_id_pc;
    logic [2:0]  s_buf_count;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    // One clock of stimulus, checking and model update.
    task automatic do_cycle(input bit redir_now, input logic [31:0] rpc);
        bit          redir;
        bit          exp_req;
        int          ndrop;
        mreq_t       r;
        logic [31:0] tgt;
        @(negedge clock);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(mq[0].addr);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
        imem_ready = mem_block ? 1'b0 : (mem_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        id_ready   = idr_rand ? 1'($urandom_range(0, 1)) : idr;
        redir = redir_now;
        tgt   = rpc;
        if (redir_on_resp && imem_valid && id_valid) begin
            redir = 1'b1;
            tgt   = auto_pc;
            redir_on_resp = 0;
        end
        redirect    = redir;
        redirect_pc = tgt;
        #1;
        ndrop = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) ndrop++;
        check_eq("buf_count", 64'(buf_count), 64'(sb.size()));
        check_eq("id_valid", 64'(id_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_eq("id_pc", 64'(id_pc), 64'(sb[0].pc));
            check_eq("id_instr", 64'(id_instr), 64'(sb[0].instr));
        end else begin
            check_eq("bubble_pc", 64'(id_pc), 64'h0);
            check_eq("bubble_instr", 64'(id_instr), 64'h0);
        end
        exp_req = !redir && (mq.size() < MAXO) && ((sb.size() + mq.size() - ndrop) < DEPTH);
        check_eq("imem_req", 64'(imem_req), 64'(exp_req));
        if (imem_req) check_eq("imem_addr", 64'(imem_addr), 64'(exp_fetch));
        if (id_valid && first_valid < 0) first_valid = cyc;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_buf_count = buf_count;
        if (id_valid && id_ready && !redir && sb.size() > 0) begin
            void'(sb.pop_front());
            pops++;
        end
        if (imem_valid) begin
            r = mq.pop_front();
            if (!redir && r.epoch == epoch) sb.push_back('{pc: r.addr, instr: mem_word(r.addr)});
        end
        if (imem_req && imem_ready) begin
            mq.push_back('{addr: imem_addr, due: cyc + lat, epoch: epoch});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (mq.size() > max_infl) max_infl = mq.size();
        if (redir) begin
            sb.delete();
            epoch++;
            exp_fetch = {tgt[31:2], 2'b00};
        end
        @(posedge clock);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle(1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        imem_ready = 1'b0;
        imem_valid = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        #1;
        check_eq("rst_id_valid", 64'(id_valid), 64'h0);
        check_eq("rst_buf_count", 64'(buf_count), 64'h0);
        check_eq("rst_imem_req", 64'(imem_req), 64'h0);
        check_eq("rst_id_pc", 64'(id_pc), 64'h0);
        check_eq("rst_id_instr", 64'(id_instr), 64'h0);
        mq.delete();
        sb.delete();
        epoch++;
        exp_fetch = INIT_PC;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("rst_release_addr", 64'(imem_addr), 64'(INIT_PC));
    endtask

    initial begin
        apply_reset();

        // Zero-wait streaming: first word at the third cycle, then one per cycle.
        cyc = 0; first_valid = -1; pops = 0; lat = 1; idr = 1;
        run(20);
        check_eq("first_valid_cycle", 64'(first_valid), 64'd2);
        check_eq("stream_pops", 64'(pops), 64'd18);

        // Decode stalls: buffer fills to DEPTH and fetch stops.
        idr = 0;
        run(10);
        check_eq("full_count", 64'(s_buf_count), 64'd4);
        check_eq("full_inflight", 64'(mq.size()), 64'd0);
        idr = 1;
        run(10);

        // Drain, then a 4-cycle memory saturates the outstanding limit.
        mem_block = 1;
        run(8);
        mem_block = 0; lat = 4; max_infl = 0;
        run(30);
        check_eq("max_inflight", 64'(max_infl), 64'd4);

        // Redirect with two requests in flight.
        mem_block = 1; lat = 3;
        run(10);
        mem_block = 0;
        run(2);
        check_eq("pre_redir_inflight", 64'(mq.size()), 64'd2);
        do_cycle(1'b1, 32'h0000_0100);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 32'h0);
            if (s_id_valid) break;
        end
        check_eq("redir_first_valid", 64'(s_id_valid), 64'h1);
        check_eq("redir_first_pc", 64'(s_id_pc), 64'h100);
        do_cycle(1'b0, 32'h0);
        check_eq("redir_second_pc", 64'(s_id_pc), 64'h104);

        // Redirect coinciding with a response and a ready decode.
        lat = 2; redir_on_resp = 1;
        for (int i = 0; i < 30; i++) begin
            if (!redir_on_resp) break;
            do_cycle(1'b0, 32'h0);
        end
        check_eq("resp_redir_fired", 64'(redir_on_resp), 64'h0);
        do_cycle(1'b0, 32'h0);
        check_eq("resp_redir_flush_valid", 64'(s_id_valid), 64'h0);
        check_eq("resp_redir_flush_count", 64'(s_buf_count), 64'h0);
        run(12);

        // Random backpressure and redirects.
        mem_rand = 1; idr_rand = 1; lat = 2;
        for (int i = 0; i < 300; i++) begin
            do_cycle($urandom_range(0, 15) == 0, $urandom);
        end
        mem_rand = 0; idr_rand = 0;

        // Reset with two entries buffered.
        lat = 1; idr = 0;
        do_cycle(1'b1, 32'h0000_0040);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 32'h0);
            if (sb.size() == 2) break;
        end
        check_eq("pre_rst_buffered", 64'(sb.size()), 64'd2);
        apply_reset();
        idr = 1; cyc = 0; first_valid = -1;
        run(20);
        check_eq("post_rst_first_valid", 64'(first_valid), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
